switch_debounce: RTL and testbench

- Conditioning stage directly upstream of the 7-segment display driver.
- Synchronises and debounces the raw slide switches and emits a clean per-bit level plus one-cycle rise/fall pulses.
- Counts accepted switch changes.
- Presents a registered 16-bit display word, {change_count, stable switches}, that feeds the four hex digits in place of raw switch wiring.

---
 rtl/switch_debounce_if.sv | 23 ++
 rtl/switch_debounce.sv | 92 +++++++++
 tb/tb_switch_debounce.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/switch_debounce_if.sv
// Signal bundle between the raw switch inputs and the conditioned outputs
// that feed the 7-segment display driver.
interface switch_debounce_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] switch;
    logic             count_clr;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic [7:0]       change_count;
    logic [15:0]      disp_value;

    modport master (
        output switch, count_clr,
        input  sw_stable, sw_rise, sw_fall, change_count, disp_value
    );

    modport slave (
        input  switch, count_clr,
        output sw_stable, sw_rise, sw_fall, change_count, disp_value
    );
endinterface

// File: rtl/switch_debounce.sv
// Synchronises and debounces slide switches, emits rise/fall pulses, counts
// accepted changes and presents a registered {change_count, switches} word.
module switch_debounce #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 32768,
    parameter int CNT_W         = 15
) (
    input  logic            clk,
    input  logic            nReset,
    switch_debounce_if.slave sif
);
    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_sw_stable;
    logic [WIDTH-1:0] r_sw_rise;
    logic [WIDTH-1:0] r_sw_fall;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [7:0]       r_change_count;
    logic [15:0]      r_disp_value;

    logic [WIDTH-1:0] w_stable_nxt;
    logic [WIDTH-1:0] w_rise_nxt;
    logic [WIDTH-1:0] w_fall_nxt;
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic             w_any_edge;

    // NOTE: every output of this block gets a default before the loop, so no
    // path through it can leave a value unassigned and infer a latch.
    always_comb begin
        w_stable_nxt = r_sw_stable;
        w_rise_nxt   = '0;
        w_fall_nxt   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_sw_stable[i]) begin
                if (r_cnt[i] == LP_CNT_MAX) begin
                    w_stable_nxt[i] = r_sync2[i];
                    w_rise_nxt[i]   = r_sync2[i];
                    w_fall_nxt[i]   = ~r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_any_edge = |(w_rise_nxt | w_fall_nxt);

    // NOTE: state uses non-blocking assignments so every flop samples the
    // values from before this edge, which is what makes r_sync1->r_sync2 a
    // true two-stage synchroniser.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_sync1        <= '0;
            r_sync2        <= '0;
            r_sw_stable    <= '0;
            r_sw_rise      <= '0;
            r_sw_fall      <= '0;
            r_change_count <= '0;
            r_disp_value   <= '0;
            // NOTE: the counter array is reset so a partial count never
            // survives reset; this is deliberate, not a free RAM-style array.
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1     <= sif.switch;
            r_sync2     <= r_sync1;
            r_sw_stable <= w_stable_nxt;
            r_sw_rise   <= w_rise_nxt;
            r_sw_fall   <= w_fall_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (sif.count_clr) begin
                r_change_count <= '0;
            end else if (w_any_edge) begin
                r_change_count <= r_change_count + 8'd1;
            end
            // Low byte is the previous-cycle stable level, resized to 8 bits.
            r_disp_value <= {r_change_count, 8'(r_sw_stable)};
        end
    end

    assign sif.sw_stable    = r_sw_stable;
    assign sif.sw_rise      = r_sw_rise;
    assign sif.sw_fall      = r_sw_fall;
    assign sif.change_count = r_change_count;
    assign sif.disp_value   = r_disp_value;
endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: a cycle model pushes expected outputs into a
// scoreboard queue, checked on the falling edge, plus directed timing checks.
module tb_switch_debounce;
    localparam int WIDTH  = 8;
    localparam int STABLE = 4;
    localparam int CNT_W  = 3;

    typedef struct {
        logic [7:0]  stable;
        logic [7:0]  rise;
        logic [7:0]  fall;
        logic [7:0]  cc;
        logic [15:0] disp;
    } exp_t;

    logic clk;
    logic nReset;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];

    switch_debounce_if #(.WIDTH(WIDTH)) sif ();

    switch_debounce #(
        .WIDTH(WIDTH),
        .STABLE_CYCLES(STABLE),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .nReset(nReset),
        .sif(sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: counts how long the synchronised level has disagreed
    // with the accepted level and accepts on the STABLE-th such cycle.
    logic [7:0]  m_sync1, m_sync2, m_stable, m_cc;
    int          m_run [WIDTH];
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge nReset);
            if (!nReset) begin
                m_sync1  = '0;
                m_sync2  = '0;
                m_stable = '0;
                m_cc     = '0;
                for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
                q.delete();
            end else begin
                e.disp = {m_cc, m_stable};
                e.rise = '0;
                e.fall = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (m_sync2[i] !== m_stable[i]) begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == STABLE) begin
                            m_stable[i] = m_sync2[i];
                            if (m_sync2[i]) e.rise[i] = 1'b1;
                            else            e.fall[i] = 1'b1;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
                if (sif.count_clr)          m_cc = '0;
                else if (|(e.rise | e.fall)) m_cc = m_cc + 8'd1;
                e.stable = m_stable;
                e.cc     = m_cc;
                m_sync2  = m_sync1;
                m_sync1  = sif.switch;
                q.push_back(e);
            end
        end
    end

    // Scoreboard consumer: compare every produced cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!nReset) begin
                check("rst_stable", 32'(sif.sw_stable), 32'h0);
                check("rst_pulses", 32'(sif.sw_rise | sif.sw_fall), 32'h0);
                check("rst_count", 32'(sif.change_count), 32'h0);
                check("rst_disp", 32'(sif.disp_value), 32'h0);
            end else begin
                while (q.size() > 0) begin
                    e = q.pop_front();
                    check("sb_stable", 32'(sif.sw_stable), 32'(e.stable));
                    check("sb_rise", 32'(sif.sw_rise), 32'(e.rise));
                    check("sb_fall", 32'(sif.sw_fall), 32'(e.fall));
                    check("sb_count", 32'(sif.change_count), 32'(e.cc));
                    check("sb_disp", 32'(sif.disp_value), 32'(e.disp));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        nReset        = 1'b1;
        sif.switch    = 8'hFF;
        sif.count_clr = 1'b0;
        #2 nReset = 1'b0;
        cyc(3);
        check("por_stable", 32'(sif.sw_stable), 32'h0);
        check("por_disp", 32'(sif.disp_value), 32'h0);

        // Power-on acceptance at cycle 6 after release.
        nReset = 1'b1;
        cyc(5);
        check("por_rise_early", 32'(sif.sw_rise), 32'h0);
        cyc(1);
        check("por_rise", 32'(sif.sw_rise), 32'hFF);
        check("por_stable_ff", 32'(sif.sw_stable), 32'hFF);
        check("por_count", 32'(sif.change_count), 32'd1);
        cyc(1);
        check("por_disp_01ff", 32'(sif.disp_value), 32'h01FF);
        check("por_rise_gone", 32'(sif.sw_rise), 32'h0);

        sif.switch = 8'h00;
        cyc(10);
        check("clear_all_count", 32'(sif.change_count), 32'd2);

        // Glitch of 3 cycles is rejected.
        sif.switch = 8'h08;
        cyc(3);
        sif.switch = 8'h00;
        cyc(10);
        check("glitch_stable", 32'(sif.sw_stable), 32'h00);
        check("glitch_count", 32'(sif.change_count), 32'd2);

        // 5-cycle pulse is accepted, then released.
        sif.switch = 8'h08;
        cyc(5);
        sif.switch = 8'h00;
        cyc(1);
        check("pulse_rise", 32'(sif.sw_rise), 32'h08);
        check("pulse_count_rise", 32'(sif.change_count), 32'd3);
        cyc(5);
        check("pulse_fall", 32'(sif.sw_fall), 32'h08);
        check("pulse_count_fall", 32'(sif.change_count), 32'd4);
        cyc(5);

        // Simultaneous acceptance counts once.
        sif.switch = 8'h81;
        cyc(5);
        check("simul_early", 32'(sif.sw_rise), 32'h0);
        cyc(1);
        check("simul_rise", 32'(sif.sw_rise), 32'h81);
        check("simul_count", 32'(sif.change_count), 32'd5);
        cyc(1);
        check("simul_rise_gone", 32'(sif.sw_rise), 32'h0);
        sif.switch = 8'h00;
        cyc(10);
        check("simul_fall_count", 32'(sif.change_count), 32'd6);

        // Clear in the same cycle as an accepted edge.
        sif.switch = 8'h01;
        cyc(5);
        sif.count_clr = 1'b1;
        cyc(1);
        sif.count_clr = 1'b0;
        check("clr_edge_count", 32'(sif.change_count), 32'd0);
        check("clr_edge_stable", 32'(sif.sw_stable), 32'h01);
        check("clr_edge_rise", 32'(sif.sw_rise), 32'h01);
        cyc(3);

        // 256 accepted toggles wrap the counter back to 0.
        for (int t = 0; t < 256; t++) begin
            sif.switch = sif.switch ^ 8'h01;
            cyc(7);
            if (t == 254) check("wrap_255", 32'(sif.change_count), 32'd255);
        end
        check("wrap_zero", 32'(sif.change_count), 32'd0);
        check("wrap_stable", 32'(sif.sw_stable), 32'h01);

        // Async reset while bit 0 is mid-count.
        sif.switch = 8'h00;
        cyc(10);
        sif.switch = 8'h01;
        cyc(4);
        #2 nReset = 1'b0;
        #1;
        check("arst_count", 32'(sif.change_count), 32'd0);
        check("arst_disp", 32'(sif.disp_value), 32'h0);
        check("arst_stable", 32'(sif.sw_stable), 32'h0);
        cyc(2);
        nReset = 1'b1;
        cyc(5);
        check("arst_rise_early", 32'(sif.sw_rise), 32'h0);
        cyc(1);
        check("arst_rise", 32'(sif.sw_rise), 32'h01);
        check("arst_rise_count", 32'(sif.change_count), 32'd1);

        // Bit 5 bounces every 2 cycles while bit 2 steps clean.
        for (int k = 0; k < 12; k++) begin
            sif.switch = 8'h05 | (k[1] ? 8'h20 : 8'h00);
            cyc(1);
            if (k == 4) check("indep_early", 32'(sif.sw_rise), 32'h0);
            if (k == 5) begin
                check("indep_rise", 32'(sif.sw_rise), 32'h04);
                check("indep_stable", 32'(sif.sw_stable), 32'h05);
            end
        end
        sif.switch = 8'h05;
        cyc(10);
        check("indep_final", 32'(sif.sw_stable), 32'h05);
        check("indep_count", 32'(sif.change_count), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
